// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Carry into chunk 0: fixed for ADD/SUB, flag-driven for ADC/SBC.
    function automatic logic op_cin(input op_e op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-linked chunk of the adder: sum, carry-out and chunk-is-zero.
module addsub_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    assign sum  = full[W-1:0];
    assign cout = full[W];
    assign zero = (full[W-1:0] == '0);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub with NZCV flags: one carry-linked chunk per stage,
// operands skewed forward, low result chunks deskewed to the last stage.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic adv;

    // Values entering stage k: index 0 from the ports, index k from stage k-1 registers.
    logic [WIDTH-1:0] a_l   [STAGES];
    logic [WIDTH-1:0] bp_l  [STAGES];
    logic [WIDTH-1:0] r_l   [STAGES];
    logic             cy_l  [STAGES];
    logic             z_l   [STAGES];
    logic             vld_l [STAGES];
    logic [TAG_W-1:0] tag_l [STAGES];

    // A stalled output freezes the whole pipe; bubbles are kept.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    assign a_l[0]   = in_a;
    assign bp_l[0]  = is_sub(in_op) ? ~in_b : in_b;
    assign r_l[0]   = '0;
    assign cy_l[0]  = op_cin(in_op, in_cin);
    assign z_l[0]   = 1'b1;
    assign vld_l[0] = in_valid;
    assign tag_l[0] = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;

        logic [CHUNK-1:0] s_sum;
        logic             s_cout;
        logic             s_zero;
        logic [WIDTH-1:0] r_next;

        addsub_slice #(.W(CHUNK)) u_slice (
            .a    (a_l[k][LO +: CHUNK]),
            .b    (bp_l[k][LO +: CHUNK]),
            .cin  (cy_l[k]),
            .sum  (s_sum),
            .cout (s_cout),
            .zero (s_zero)
        );

        always_comb begin
            r_next             = r_l[k];
            r_next[LO +: CHUNK] = s_sum;
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] bp_q;
            logic [WIDTH-1:0] r_q;
            logic             cy_q;
            logic             z_q;
            logic             vld_q;
            logic [TAG_W-1:0] tag_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q   <= '0;
                    bp_q  <= '0;
                    r_q   <= '0;
                    cy_q  <= 1'b0;
                    z_q   <= 1'b0;
                    vld_q <= 1'b0;
                    tag_q <= '0;
                end else if (adv) begin
                    a_q   <= a_l[k];
                    bp_q  <= bp_l[k];
                    r_q   <= r_next;
                    cy_q  <= s_cout;
                    z_q   <= z_l[k] & s_zero;
                    vld_q <= vld_l[k];
                    tag_q <= tag_l[k];
                end
            end

            assign a_l[k+1]   = a_q;
            assign bp_l[k+1]  = bp_q;
            assign r_l[k+1]   = r_q;
            assign cy_l[k+1]  = cy_q;
            assign z_l[k+1]   = z_q;
            assign vld_l[k+1] = vld_q;
            assign tag_l[k+1] = tag_q;
        end else begin : g_last
            nzcv_t flags_next;
            nzcv_t flags_q;

            always_comb begin
                flags_next   = '0;
                flags_next.n = r_next[WIDTH-1];
                flags_next.z = z_l[k] & s_zero;
                flags_next.c = s_cout;
                flags_next.v = (a_l[k][WIDTH-1] == bp_l[k][WIDTH-1]) &&
                               (r_next[WIDTH-1] != a_l[k][WIDTH-1]);
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid  <= 1'b0;
                    out_result <= '0;
                    out_tag    <= '0;
                    flags_q    <= '0;
                end else if (adv) begin
                    out_valid  <= vld_l[k];
                    out_result <= r_next;
                    out_tag    <= tag_l[k];
                    flags_q    <= flags_next;
                end
            end

            assign out_n = flags_q.n;
            assign out_z = flags_q.z;
            assign out_c = flags_q.c;
            assign out_v = flags_q.v;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three configurations share one stimulus stream and are
// scored against an arithmetic reference; the 64/4 instance also gets directed vectors.
module tb_addsub_pipe;
    import addsub_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  nzcv;
        logic [4:0]  tag;
        int          acc;
        int          stalls;
    } exp_t;

    typedef struct {
        op_e         op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    op_e         in_op = OP_ADD;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_ready0 = 1'b1;
    logic        one = 1'b1;

    logic        rdy_0, rdy_1, rdy_2;
    logic        ov_0, ov_1, ov_2;
    logic [63:0] res_0, res_1;
    logic [31:0] res_2;
    logic        n_0, z_0, c_0, v_0, n_1, z_1, c_1, v_1, n_2, z_2, c_2, v_2;
    logic [4:0]  tag_0, tag_1, tag_2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pops [3];
    exp_t q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(5)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_0),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ov_0), .out_ready(out_ready0), .out_result(res_0),
        .out_n(n_0), .out_z(z_0), .out_c(c_0), .out_v(v_0), .out_tag(tag_0)
    );

    addsub_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ov_1), .out_ready(one), .out_result(res_1),
        .out_n(n_1), .out_z(z_1), .out_c(c_1), .out_v(v_1), .out_tag(tag_1)
    );

    addsub_pipe #(.WIDTH(32), .STAGES(8), .TAG_W(5)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_2),
        .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ov_2), .out_ready(one), .out_result(res_2),
        .out_n(n_2), .out_z(z_2), .out_c(c_2), .out_v(v_2), .out_tag(tag_2)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on w-bit operands, overflow from true signed sum.
    function automatic exp_t model(input op_e op, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input int w, input logic [4:0] tag);
        exp_t e;
        logic [64:0] mask, am, bp, ci, full, r;
        logic signed [66:0] sa, sb, s, lim;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, a} & mask;
        bp   = (op == OP_SUB || op == OP_SBC) ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        case (op)
            OP_ADD:  ci = 65'd0;
            OP_SUB:  ci = 65'd1;
            default: ci = {64'd0, cin};
        endcase
        full = am + bp + ci;
        r    = full & mask;
        sa   = $signed({2'b00, am});
        if (am[w-1]) sa = sa - (67'sd1 <<< w);
        sb   = $signed({2'b00, bp});
        if (bp[w-1]) sb = sb - (67'sd1 <<< w);
        s    = sa + sb + $signed({66'd0, ci[0]});
        lim  = 67'sd1 <<< (w - 1);
        e.res    = r[63:0];
        e.nzcv   = {r[w-1], (r == 65'd0), full[w], ((s >= lim) || (s < -lim))};
        e.tag    = tag;
        e.acc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    task automatic mon(input int d, input int s, input int w, input logic fire,
                       input logic rdy_out, input logic ov, input logic [63:0] res,
                       input logic [3:0] f, input logic [4:0] otag);
        exp_t e;
        logic stall;
        stall = ov && !rdy_out;
        if (stall) foreach (q[d][i]) q[d][i].stalls++;
        if (ov) begin
            if (q[d].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon%0d_spurious got=valid exp=idle res=%0h (t=%0t)", d, res, $time);
            end else begin
                e = q[d][0];
                check($sformatf("mon%0d_data", d), {res, f, otag}, {e.res, e.nzcv, e.tag});
                if (!stall) begin
                    check($sformatf("mon%0d_latency", d), 128'(cyc), 128'(e.acc + s - 1 + e.stalls));
                    void'(q[d].pop_front());
                    pops[d]++;
                end
            end
        end
        if (fire) begin
            e = model(in_op, in_a, in_b, in_cin, w, in_tag);
            e.acc = cyc + 1;
            q[d].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, 4, 64, in_valid && rdy_0, out_ready0, ov_0, res_0, {n_0, z_0, c_0, v_0}, tag_0);
            mon(1, 1, 64, in_valid && rdy_1, one, ov_1, res_1, {n_1, z_1, c_1, v_1}, tag_1);
            mon(2, 8, 32, in_valid && rdy_2, one, ov_2, {32'd0, res_2}, {n_2, z_2, c_2, v_2}, tag_2);
        end
    end

    always @(negedge reset_n) begin
        for (int d = 0; d < 3; d++) q[d].delete();
    end

    task automatic send(input op_e op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [4:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_tag = tag;
        @(negedge clk);
        while (!rdy_0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=not_ready exp=ready (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [9];
        int   lat;
        int   p0;
        bit   done;

        tv[0] = '{OP_ADD, 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000};
        tv[1] = '{OP_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        tv[2] = '{OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 4'b0110};
        tv[3] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
        tv[4] = '{OP_ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b0110};
        tv[5] = '{OP_SBC, 64'd5, 64'd3, 1'b0, 64'd1, 4'b0010};
        tv[6] = '{OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
        tv[7] = '{OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        tv[8] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};

        for (int d = 0; d < 3; d++) pops[d] = 0;

        // Reset state
        #12;
        check("rst_valid", ov_0, 0);
        check("rst_result", res_0, 0);
        check("rst_flags", {n_0, z_0, c_0, v_0}, 0);
        check("rst_tag", tag_0, 0);
        check("rst_in_ready", rdy_0, 1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        idle(1);

        // Directed vectors, one at a time
        for (int i = 0; i < 9; i++) begin
            send(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, 5'(i));
            lat = 0;
            while (!ov_0 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("tv%0d_latency", i), 128'(lat), 128'(3));
            check($sformatf("tv%0d_result", i), res_0, tv[i].res);
            check($sformatf("tv%0d_nzcv", i), {n_0, z_0, c_0, v_0}, tv[i].nzcv);
            check($sformatf("tv%0d_tag", i), tag_0, 5'(i));
            idle(1);
        end
        idle(10);

        // Back-to-back stream of 8 with a 3-cycle output stall mid-stream
        p0 = pops[0];
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(op_e'($urandom_range(3)), rand64(), rand64(), 1'($urandom_range(1)), 5'(t));
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready0 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", rdy_0, 0);
                    check("stall_out_valid", ov_0, 1);
                end
                @(posedge clk);
                #1 out_ready0 = 1'b1;
            end
        join
        idle(12);
        check("stream_count", 128'(pops[0] - p0), 128'(8));

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    send(op_e'($urandom_range(3)), rand64(), rand64(), 1'($urandom_range(1)), 5'($urandom));
                    if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready0 = ($urandom_range(3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready0 = 1'b1;
        idle(20);
        for (int d = 0; d < 3; d++) check($sformatf("drain_q%0d", d), 128'(q[d].size()), 128'(0));

        // Reset with operations in flight
        for (int t = 0; t < 4; t++) send(OP_ADD, 64'(t + 10), 64'd1, 1'b0, 5'(20 + t));
        check("pre_rst_valid", ov_0, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", {ov_0, ov_1, ov_2}, 0);
        check("async_rst_result", res_0, 0);
        check("async_rst_flags_tag", {n_0, z_0, c_0, v_0, tag_0}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_idle", {ov_0, ov_1, ov_2}, 0);
        end
        check("post_rst_ready", rdy_0, 1);
        @(posedge clk);
        #1;
        send(OP_ADD, 64'd100, 64'd23, 1'b0, 5'd9);
        lat = 0;
        while (!ov_0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("fresh_latency", 128'(lat), 128'(3));
        check("fresh_result", {res_0, n_0, z_0, c_0, v_0, tag_0}, {64'd123, 4'b0000, 5'd9});
        idle(12);
        for (int d = 0; d < 3; d++) check($sformatf("final_q%0d", d), 128'(q[d].size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
